// File: rtl/frame_redraw_ctrl.sv
// Turns qualified note-switch patterns into one-shot full-frame redraws of the
// 160x120 framebuffer by sweeping the picture ROM and issuing one pixel write per word.
module frame_redraw_ctrl #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int ROM_LAT    = 1,
  parameter int STABLE_CYC = 500000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  sw,
  input  logic [2:0]  rom_data,
  output logic [2:0]  img_sel,
  output logic [14:0] rom_address,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        busy,
  output logic        done
);

  localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [14:0] HR = 15'(H_RES);
  localparam logic [3:0] CODE_BLANK = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, FLUSH} state_t;
  state_t r_state, w_next;

  logic [7:0]  r_sw1, r_sw2;
  logic [3:0]  w_code, r_code, r_acc, r_sel, r_disp;
  logic [CW-1:0] r_cnt;
  logic [7:0]  r_px, w_pxn;
  logic [6:0]  r_py, w_pyn;
  logic        w_last;
  logic [ROM_LAT-1:0] r_vld;
  logic [7:0]  r_xs [ROM_LAT];
  logic [6:0]  r_ys [ROM_LAT];

  // Row base address py*H_RES built from shifted copies of py, one per set bit of H_RES.
  function automatic logic [14:0] rowBase(input logic [6:0] row);
    logic [14:0] acc;
    acc = '0;
    for (int b = 0; b < 15; b++)
      if (HR[b]) acc = acc + (15'(row) << b);
    return acc;
  endfunction

  // Lowest-index set switch wins; no switch selects the blank image.
  always_comb begin
    w_code = CODE_BLANK;
    for (int i = 7; i >= 0; i--)
      if (r_sw2[i]) w_code = 4'(i);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sw1  <= '0;
      r_sw2  <= '0;
      r_code <= 4'hF;
      r_cnt  <= '0;
      r_acc  <= 4'hF;
    end else begin
      r_sw1 <= sw;
      r_sw2 <= r_sw1;
      if (w_code != r_code) begin
        r_code <= w_code;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_acc <= r_code;
      end
    end
  end

  always_comb begin
    w_last = (r_px == 8'(H_RES - 1)) && (r_py == 7'(V_RES - 1));
    if (r_px == 8'(H_RES - 1)) begin
      w_pxn = '0;
      w_pyn = r_py + 1'b1;
    end else begin
      w_pxn = r_px + 1'b1;
      w_pyn = r_py;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    case (r_state)
      IDLE:    if (r_acc != r_disp) w_next = LOAD;
      LOAD:    w_next = DRAW;
      DRAW:    if (w_last) w_next = FLUSH;
      FLUSH:   if (r_vld == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // rom_address/r_px/r_py always name the same pixel, so the DRAW cycle that shows an address also tags it.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sel       <= 4'hF;
      r_disp      <= 4'hF;
      img_sel     <= '0;
      r_px        <= '0;
      r_py        <= '0;
      rom_address <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (w_next == LOAD) r_sel <= r_acc;
        LOAD: begin
          img_sel     <= (r_sel == CODE_BLANK) ? 3'd0 : r_sel[2:0];
          r_px        <= '0;
          r_py        <= '0;
          rom_address <= '0;
        end
        DRAW: if (!w_last) begin
          r_px        <= w_pxn;
          r_py        <= w_pyn;
          rom_address <= rowBase(w_pyn) + 15'(w_pxn);
        end
        FLUSH: if (r_vld == '0) begin
          r_disp <= r_sel;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      writeEn <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_xs[i] <= '0;
        r_ys[i] <= '0;
      end
    end else begin
      r_vld[0] <= (r_state == DRAW);
      r_xs[0]  <= r_px;
      r_ys[0]  <= r_py;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_xs[i]  <= r_xs[i-1];
        r_ys[i]  <= r_ys[i-1];
      end
      writeEn <= r_vld[ROM_LAT-1];
      if (r_vld[ROM_LAT-1]) begin
        x      <= r_xs[ROM_LAT-1];
        y      <= r_ys[ROM_LAT-1];
        colour <= (r_sel == CODE_BLANK) ? 3'd0 : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_redraw_ctrl.sv
// Directed bench for frame_redraw_ctrl: a ROM_LAT=1 and a ROM_LAT=3 instance share
// clock, reset and switches; negedge monitors track every pixel write against a raster model.
module tb_frame_redraw_ctrl;

  localparam int NPIX = 19200;

  logic clock;
  logic reset;
  logic [7:0] sw;

  logic [2:0]  romData1, sel1, col1, romData3, sel3, col3;
  logic [14:0] addr1, addr3;
  logic [7:0]  x1, x3;
  logic [6:0]  y1, y3;
  logic        we1, busy1, done1, we3, busy3, done3;
  logic [2:0]  romPipe3 [3];

  int testsRun = 0;
  int testsFailed = 0;
  bit expBlank = 1'b1;

  frame_redraw_ctrl #(.H_RES(160), .V_RES(120), .ROM_LAT(1), .STABLE_CYC(4)) dut (
    .CLOCK_50(clock), .reset(reset), .sw(sw), .rom_data(romData1), .img_sel(sel1),
    .rom_address(addr1), .x(x1), .y(y1), .colour(col1), .writeEn(we1), .busy(busy1), .done(done1)
  );

  frame_redraw_ctrl #(.H_RES(160), .V_RES(120), .ROM_LAT(3), .STABLE_CYC(4)) dut3 (
    .CLOCK_50(clock), .reset(reset), .sw(sw), .rom_data(romData3), .img_sel(sel3),
    .rom_address(addr3), .x(x3), .y(y3), .colour(col3), .writeEn(we3), .busy(busy3), .done(done3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM models: every image returns the low three address bits after ROM_LAT cycles.
  always @(posedge clock) begin
    romData1    <= addr1[2:0];
    romPipe3[0] <= addr3[2:0];
    romPipe3[1] <= romPipe3[0];
    romPipe3[2] <= romPipe3[1];
  end
  assign romData3 = romPipe3[2];

  int cyc = 0;
  int wr1 = 0, pix1 = 0, seqErr1 = 0, colErr1 = 0, gapErr1 = 0, selErr1 = 0;
  int doneCnt1 = 0, doneErr1 = 0, starts1 = 0, busyRise1 = 0, firstLat1 = -1;
  int firstX1 = -1, firstY1 = -1, lastX1 = -1, lastY1 = -1, col51_1 = -1;
  int startSel1 [8] = '{default: 0};
  logic [2:0] frameSel1 = '0;
  bit prevBusy1 = 0, prevFinal1 = 0;

  int pix3 = 0, seqErr3 = 0, colErr3 = 0, busyRise3 = 0, firstLat3 = -1, col51_3 = -1;
  bit prevBusy3 = 0;

  // Raster model for the ROM_LAT=1 instance.
  always @(negedge clock) begin
    int expCol;
    bit isFinal;
    cyc++;
    isFinal = 0;
    if (reset) begin
      pix1 = 0; prevBusy1 = 0; prevFinal1 = 0;
    end else begin
      if (busy1 && !prevBusy1) busyRise1 = cyc;
      if (we1) begin
        if (pix1 == 0) begin
          starts1++; startSel1[sel1]++; frameSel1 = sel1;
          firstLat1 = cyc - busyRise1; firstX1 = x1; firstY1 = y1;
        end
        if (sel1 != frameSel1) selErr1++;
        if (int'(x1) != pix1 % 160 || int'(y1) != pix1 / 160) seqErr1++;
        expCol = expBlank ? 0 : (int'(y1) * 160 + int'(x1)) % 8;
        if (int'(col1) != expCol) colErr1++;
        if (x1 == 8'd5 && y1 == 7'd1) col51_1 = col1;
        lastX1 = x1; lastY1 = y1;
        isFinal = (pix1 == NPIX - 1);
        wr1++;
        pix1 = isFinal ? 0 : pix1 + 1;
      end else if (pix1 != 0) begin
        gapErr1++;
      end
      if (done1) begin
        doneCnt1++;
        if (!prevFinal1) doneErr1++;
      end
      prevBusy1 = busy1;
      prevFinal1 = isFinal;
    end
  end

  // Raster model for the ROM_LAT=3 instance.
  always @(negedge clock) begin
    int expCol;
    if (reset) begin
      pix3 = 0; prevBusy3 = 0;
    end else begin
      if (busy3 && !prevBusy3) busyRise3 = cyc;
      if (we3) begin
        if (pix3 == 0) firstLat3 = cyc - busyRise3;
        if (int'(x3) != pix3 % 160 || int'(y3) != pix3 / 160) seqErr3++;
        expCol = expBlank ? 0 : (int'(y3) * 160 + int'(x3)) % 8;
        if (int'(col3) != expCol) colErr3++;
        if (x3 == 8'd5 && y3 == 7'd1) col51_3 = col3;
        pix3 = (pix3 == NPIX - 1) ? 0 : pix3 + 1;
      end
      prevBusy3 = busy3;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    int d0 = doneCnt1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (doneCnt1 != d0) begin ok = 1; break; end
    end
  endtask

  task automatic waitPix(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pix1 == target) begin ok = 1; break; end
    end
  endtask

  task automatic waitStart(input int budget, output bit ok);
    int s0 = starts1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (starts1 != s0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    sw = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();
    testsRun++; if (we1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_writeEn: got %b expected 0", we1); end
    testsRun++; if (busy1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy1); end
    testsRun++; if (done1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done1); end
    testsRun++; if (sel1 !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_img_sel: got %0d expected 0", sel1); end
    testsRun++; if (addr1 !== 15'd0) begin testsFailed++; $display("[TB] FAIL reset_rom_address: got %0d expected 0", addr1); end
    testsRun++; if ({x1, y1, col1} !== 18'd0) begin testsFailed++; $display("[TB] FAIL reset_xyc: got %0d/%0d/%0d expected 0/0/0", x1, y1, col1); end
    testsRun++; if ({we3, busy3, done3} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_lat3: got %b expected 000", {we3, busy3, done3}); end
    reset = 1'b0;
  endtask

  task automatic test_blank_frame();
    int w0 = wr1, d0 = doneCnt1;
    bit ok;
    expBlank = 1'b1;
    waitDone(25000, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL blank_done_timeout: got no done expected done"); end
    testsRun++; if (wr1 - w0 !== NPIX) begin testsFailed++; $display("[TB] FAIL blank_writes: got %0d expected %0d", wr1 - w0, NPIX); end
    testsRun++; if (firstX1 !== 0 || firstY1 !== 0) begin testsFailed++; $display("[TB] FAIL blank_first_xy: got %0d,%0d expected 0,0", firstX1, firstY1); end
    testsRun++; if (lastX1 !== 159 || lastY1 !== 119) begin testsFailed++; $display("[TB] FAIL blank_last_xy: got %0d,%0d expected 159,119", lastX1, lastY1); end
    testsRun++; if (frameSel1 !== 3'd0) begin testsFailed++; $display("[TB] FAIL blank_img_sel: got %0d expected 0", frameSel1); end
    testsRun++; if (colErr1 !== 0) begin testsFailed++; $display("[TB] FAIL blank_colour: got %0d bad pixels expected 0", colErr1); end
    testsRun++; if (firstLat1 !== 3) begin testsFailed++; $display("[TB] FAIL blank_first_latency: got %0d expected 3", firstLat1); end
    tick();
    testsRun++; if (busy1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL blank_busy_after: got %b expected 0", busy1); end
    testsRun++; if (doneCnt1 - d0 !== 1) begin testsFailed++; $display("[TB] FAIL blank_done_count: got %0d expected 1", doneCnt1 - d0); end
    repeat (10) tick();
  endtask

  task automatic test_image_select();
    int w0 = wr1, d0 = doneCnt1, s1 = startSel1[1], wEnd, sEnd;
    bit ok;
    expBlank = 1'b0;
    sw = 8'h06;
    waitDone(25000, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL sel_done_timeout: got no done expected done"); end
    testsRun++; if (startSel1[1] - s1 !== 1 || frameSel1 !== 3'd1) begin testsFailed++; $display("[TB] FAIL sel_img_sel: got %0d expected 1", frameSel1); end
    testsRun++; if (col51_1 !== 5) begin testsFailed++; $display("[TB] FAIL sel_colour_5_1: got %0d expected 5", col51_1); end
    testsRun++; if (wr1 - w0 !== NPIX) begin testsFailed++; $display("[TB] FAIL sel_writes: got %0d expected %0d", wr1 - w0, NPIX); end
    testsRun++; if (colErr1 !== 0 || seqErr1 !== 0) begin testsFailed++; $display("[TB] FAIL sel_pixels: got %0d colour/%0d order errors expected 0/0", colErr1, seqErr1); end
    testsRun++; if (gapErr1 !== 0) begin testsFailed++; $display("[TB] FAIL sel_contiguous: got %0d gaps expected 0", gapErr1); end
    testsRun++; if (doneErr1 !== 0) begin testsFailed++; $display("[TB] FAIL sel_done_timing: got %0d misplaced expected 0", doneErr1); end
    wEnd = wr1; sEnd = starts1;
    repeat (60) tick();
    testsRun++; if (doneCnt1 - d0 !== 1) begin testsFailed++; $display("[TB] FAIL sel_done_count: got %0d expected 1", doneCnt1 - d0); end
    testsRun++; if (wr1 !== wEnd || starts1 !== sEnd) begin testsFailed++; $display("[TB] FAIL sel_no_rewrite: got %0d extra writes expected 0", wr1 - wEnd); end
    testsRun++; if (firstLat3 !== 5) begin testsFailed++; $display("[TB] FAIL lat3_first_write: got %0d expected 5", firstLat3); end
    testsRun++; if (col51_3 !== 5) begin testsFailed++; $display("[TB] FAIL lat3_colour_5_1: got %0d expected 5", col51_3); end
    testsRun++; if (seqErr3 !== 0 || colErr3 !== 0) begin testsFailed++; $display("[TB] FAIL lat3_alignment: got %0d order/%0d colour errors expected 0/0", seqErr3, colErr3); end
  endtask

  task automatic test_midframe_change();
    int w0 = wr1;
    bit ok;
    sw = 8'h01;
    waitPix(5000, 30000, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL mid_reach_5000: got pixel %0d expected 5000", pix1); end
    sw = 8'h80;
    waitDone(25000, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL mid_done_timeout: got no done expected done"); end
    testsRun++; if (frameSel1 !== 3'd0 || selErr1 !== 0) begin testsFailed++; $display("[TB] FAIL mid_frozen_sel: got %0d (%0d changes) expected 0 (0)", frameSel1, selErr1); end
    testsRun++; if (wr1 - w0 !== NPIX) begin testsFailed++; $display("[TB] FAIL mid_writes: got %0d expected %0d", wr1 - w0, NPIX); end
    waitStart(200, ok);
    testsRun++; if (!ok || frameSel1 !== 3'd7) begin testsFailed++; $display("[TB] FAIL mid_second_frame: got sel %0d started %0d expected 7 1", frameSel1, ok); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    waitPix(10000, 15000, ok);
    testsRun++; if (!ok || we1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_reach_10000: got pixel %0d we %b expected 10000 1", pix1, we1); end
    reset = 1'b1;
    #1;
    testsRun++; if (we1 !== 1'b0 || busy1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_drop: got we %b busy %b expected 0 0", we1, busy1); end
    testsRun++; if (we3 !== 1'b0 || busy3 !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_drop_lat3: got we %b busy %b expected 0 0", we3, busy3); end
    repeat (2) tick();
    reset = 1'b0;
    waitStart(200, ok);
    testsRun++; if (!ok || firstX1 !== 0 || firstY1 !== 0) begin testsFailed++; $display("[TB] FAIL rst_redraw_origin: got %0d,%0d expected 0,0", firstX1, firstY1); end
    testsRun++; if (frameSel1 !== 3'd7) begin testsFailed++; $display("[TB] FAIL rst_redraw_sel: got %0d expected 7", frameSel1); end
  endtask

  task automatic test_glitch_filter();
    int s0, z0, o0;
    bit ok;
    repeat (20) tick();
    reset = 1'b1;
    sw = 8'h01;
    repeat (2) tick();
    s0 = starts1; z0 = startSel1[0]; o0 = startSel1[1];
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw = (i % 2 == 1) ? 8'h02 : 8'h01;
      repeat (2) tick();
    end
    sw = 8'h02;
    waitStart(200, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL glitch_start_timeout: got no frame expected frame"); end
    testsRun++; if (startSel1[0] - z0 !== 0) begin testsFailed++; $display("[TB] FAIL glitch_no_sel0: got %0d frames expected 0", startSel1[0] - z0); end
    testsRun++; if (startSel1[1] - o0 !== 1) begin testsFailed++; $display("[TB] FAIL glitch_sel1_frame: got %0d frames expected 1", startSel1[1] - o0); end
    repeat (50) tick();
    testsRun++; if (starts1 - s0 !== 1) begin testsFailed++; $display("[TB] FAIL glitch_single_frame: got %0d frames expected 1", starts1 - s0); end
  endtask

  initial begin
    test_reset();
    test_blank_frame();
    test_image_select();
    test_midframe_change();
    test_reset_midframe();
    test_glitch_filter();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
